// File: rtl/floo_hbm_mem_responder.sv
// floo_hbm_mem_responder: memory-side responder for one narrow HBM NoC port.
// Takes narrow AXI AW/W/AR request flits and serves them from an internal word
// memory. It answers with B/R response flits after a fixed response latency.
// Only one transaction is in flight at a time.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            request flit handshake
//   req_type_i                         0=AW 1=W 2=AR 3=reserved
//   req_id_i/req_addr_i/req_len_i      AW/AR id, start byte address, beats-1
//   req_data_i/req_strb_i/req_last_i   W beat data, byte strobes, last flag
//   rsp_valid_o/rsp_ready_i            response flit handshake
//   rsp_type_o                         0=B 1=R
//   rsp_id_o/rsp_data_o/rsp_resp_o     echoed id, read data, OKAY/SLVERR
//   rsp_last_o                         last R beat, always 1 for B
module floo_hbm_mem_responder #(
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          AddrWidth   = 48,
  parameter int unsigned          IdWidth     = 4,
  parameter int unsigned          Depth       = 256,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          RespLatency = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_type_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [7:0]             req_len_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  input  logic                   req_last_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_type_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic [DataWidth-1:0]   rsp_data_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   rsp_last_o
);
  localparam int unsigned NB = DataWidth / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned IW = $clog2(Depth);
  localparam int unsigned LW = RespLatency > 1 ? $clog2(RespLatency) : 1;
  localparam logic [AddrWidth-1:0] StepB = AddrWidth'(NB);
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(NB - 1);
  localparam logic [LW-1:0] LatLast = LW'(RespLatency - 1);
  localparam logic [1:0] TypeAw = 2'd0;
  localparam logic [1:0] TypeW = 2'd1;
  localparam logic [1:0] TypeAr = 2'd2;

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_e;
  // With zero latency the response phase follows the request handshake directly.
  localparam state_e AfterReq = (RespLatency == 0) ? RESP : WAIT;

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic                   err_q, err_d;
  logic                   rd_q, rd_d;
  logic                   rdy, hs, we, in_win;
  logic [AddrWidth-1:0]   off;
  logic [IW-1:0]          idx;
  logic [DataWidth-1:0]   mem_q [Depth];

  // addr_q always holds the address of the current beat; the window test is
  // an upper-bits-zero check because BaseAddr is aligned to the window size.
  assign off = addr_q - BaseAddr;
  assign in_win = (off >> (OW + IW)) == '0;
  assign idx = off[OW +: IW];

  // Acceptance depends on state and flit type only, never on the response side.
  assign rdy = (state_q == IDLE) ? (req_type_i == TypeAw || req_type_i == TypeAr)
                                 : (state_q == WDATA && req_type_i == TypeW);
  assign req_ready_o = rdy & rst_ni;
  assign hs = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    err_d = err_q;
    rd_d = rd_q;
    we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          id_d = req_id_i;
          addr_d = req_addr_i & ~AlignMask;
          len_d = req_len_i;
          cnt_d = '0;
          lat_d = '0;
          err_d = 1'b0;
          rd_d = req_type_i == TypeAr;
          state_d = (req_type_i == TypeAr) ? AfterReq : WDATA;
        end
      end
      WDATA: begin
        if (hs) begin
          we = in_win;
          // Sticky error: out-of-window beat, or last flag not on beat len.
          err_d = err_q | ~in_win | ((cnt_q == len_q) != req_last_i);
          addr_d = addr_q + StepB;
          cnt_d = cnt_q + 8'd1;
          if (req_last_i) begin
            lat_d = '0;
            state_d = AfterReq;
          end
        end
      end
      WAIT: begin
        if (lat_q == LatLast) state_d = RESP;
        else lat_d = lat_q + LW'(1);
      end
      RESP: begin
        if (rsp_ready_i) begin
          addr_d = addr_q + StepB;
          cnt_d = cnt_q + 8'd1;
          if (!rd_q || cnt_q == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      lat_q <= '0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (req_strb_i[b]) mem_q[idx][8*b +: 8] <= req_data_i[8*b +: 8];
      end
    end
  end

  // Response fields come straight from registered state, so they hold while stalled.
  assign rsp_valid_o = state_q == RESP;
  assign rsp_type_o = rsp_valid_o & rd_q;
  assign rsp_id_o = rsp_valid_o ? id_q : '0;
  assign rsp_data_o = (rsp_valid_o && rd_q && in_win) ? mem_q[idx] : '0;
  assign rsp_resp_o = (rsp_valid_o && (rd_q ? !in_win : err_q)) ? 2'b10 : 2'b00;
  assign rsp_last_o = rsp_valid_o & (!rd_q | (cnt_q == len_q));
endmodule

// File: tb/tb_floo_hbm_mem_responder.sv
// tb_floo_hbm_mem_responder: bench with a transaction-level memory model and response scoreboard.
module tb_floo_hbm_mem_responder;
  localparam int NB = 8;
  localparam int DEPTH = 256;
  localparam logic [47:0] BASE = '0;
  localparam logic [47:0] SPAN = 48'(NB * DEPTH);

  typedef struct packed {
    logic        t;
    logic [3:0]  id;
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } flit_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i, req_ready_o, req_last_i;
  logic [1:0]  req_type_i;
  logic [3:0]  req_id_i;
  logic [47:0] req_addr_i;
  logic [7:0]  req_len_i, req_strb_i;
  logic [63:0] req_data_i;
  logic        rsp_valid_o, rsp_type_o, rsp_last_o;
  logic        rsp_ready_i = 1'b0;
  logic [3:0]  rsp_id_o;
  logic [63:0] rsp_data_o;
  logic [1:0]  rsp_resp_o;

  flit_t       exp_q[$], got_q[$];
  logic [63:0] mdl [DEPTH];
  logic [63:0] wd[$];
  logic [7:0]  ws[$];
  int checks = 0, fails = 0, cyc = 0, hs_cyc = 0, rmode = 0;

  floo_hbm_mem_responder #(
    .DataWidth(64), .AddrWidth(48), .IdWidth(4), .Depth(DEPTH), .BaseAddr(BASE), .RespLatency(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_type_i(req_type_i),
    .req_id_i(req_id_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_data_i(req_data_i), .req_strb_i(req_strb_i), .req_last_i(req_last_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_type_o(rsp_type_o),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o), .rsp_last_o(rsp_last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Response-side consumer: always ready, random, or held off.
  always @(posedge clk_i) begin
    #1;
    rsp_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic win(input logic [47:0] a);
    logic [47:0] o;
    o = a - BASE;
    return o < SPAN;
  endfunction

  function automatic int widx(input logic [47:0] a);
    logic [47:0] o;
    o = a - BASE;
    return int'((o / 48'(NB)) % 48'(DEPTH));
  endfunction

  // Scoreboard: every handshaken response against the model; stalled outputs must hold.
  flit_t prev;
  logic  stall = 1'b0;
  always @(negedge clk_i) begin
    flit_t cur;
    cur = {rsp_type_o, rsp_id_o, rsp_data_o, rsp_resp_o, rsp_last_o};
    if (!rst_ni) stall = 1'b0;
    else begin
      if (stall) chk("hold", 80'({rsp_valid_o, cur}), 80'({1'b1, prev}));
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp got=%h exp=none", cur);
        end else chk("rsp", 80'(cur), 80'(exp_q.pop_front()));
        got_q.push_back(cur);
      end
      stall = rsp_valid_o && !rsp_ready_i;
      prev = cur;
    end
  end

  task automatic xfer(input logic [1:0] t, input logic [3:0] id, input logic [47:0] a,
                      input logic [7:0] len, input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    req_valid_i = 1'b1;
    req_type_i = t;
    req_id_i = id;
    req_addr_i = a;
    req_len_i = len;
    req_data_i = d;
    req_strb_i = s;
    req_last_i = l;
    @(negedge clk_i);
    while (!req_ready_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_accept", 80'(req_ready_o), 80'(1));
    hs_cyc = cyc;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len);
    logic err;
    logic [47:0] ba;
    int n;
    n = wd.size();
    err = (n != int'(len) + 1);
    ba = a & ~48'(NB - 1);
    xfer(2'd0, id, a, len, '0, '0, 1'b0);
    for (int k = 0; k < n; k++) begin
      if (win(ba)) begin
        for (int b = 0; b < NB; b++) if (ws[k][b]) mdl[widx(ba)][8*b +: 8] = wd[k][8*b +: 8];
      end else err = 1'b1;
      xfer(2'd1, 4'd0, '0, 8'd0, wd[k], ws[k], k == n - 1);
      ba += 48'(NB);
    end
    exp_q.push_back({1'b0, id, 64'h0, err ? 2'b10 : 2'b00, 1'b1});
    wd.delete();
    ws.delete();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len);
    logic [47:0] ba;
    ba = a & ~48'(NB - 1);
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back({1'b1, id, win(ba) ? mdl[widx(ba)] : 64'h0, win(ba) ? 2'b00 : 2'b10, k == int'(len)});
      ba += 48'(NB);
    end
    xfer(2'd2, id, a, len, '0, '0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 80'(exp_q.size()), 80'(0));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    req_valid_i = 1'b0;
    req_type_i = 2'd2;
    req_id_i = '0;
    req_addr_i = '0;
    req_len_i = '0;
    req_data_i = '0;
    req_strb_i = '0;
    req_last_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 80'(req_ready_o), 80'(0));
    chk("rst_outs", 80'({rsp_valid_o, rsp_type_o, rsp_id_o, rsp_data_o, rsp_resp_o, rsp_last_o}), 80'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    req_valid_i = 1'b1;
    req_type_i = 2'd1;
    @(negedge clk_i);
    chk("idle_w_stall", 80'(req_ready_o), 80'(0));
    req_type_i = 2'd3;
    @(negedge clk_i);
    chk("idle_rsv_stall", 80'(req_ready_o), 80'(0));
    req_valid_i = 1'b0;
    req_type_i = 2'd2;
    @(negedge clk_i);
    chk("idle_ar_ready", 80'(req_ready_o), 80'(1));
    @(posedge clk_i);
    #1;
    // Fill the whole memory with one maximum-length burst.
    for (int k = 0; k < DEPTH; k++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back(8'hFF);
    end
    do_write(4'd5, 48'h0, 8'd255);
    drain();
    // Write then read back.
    wd.push_back(64'hA5A5);
    ws.push_back(8'hFF);
    wd.push_back(64'h5A5A);
    ws.push_back(8'hFF);
    got_q.delete();
    do_write(4'd3, 48'h10, 8'd1);
    drain();
    chk("wr_b", 80'(got_q[0]), 80'({1'b0, 4'd3, 64'h0, 2'b00, 1'b1}));
    got_q.delete();
    do_read(4'd3, 48'h10, 8'd1);
    drain();
    chk("rd_beat0", 80'(got_q[0]), 80'({1'b1, 4'd3, 64'hA5A5, 2'b00, 1'b0}));
    chk("rd_beat1", 80'(got_q[1]), 80'({1'b1, 4'd3, 64'h5A5A, 2'b00, 1'b1}));
    // Latency from AR handshake cycle to first valid.
    do_read(4'd7, 48'h10, 8'd0);
    begin
      int n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (!rsp_valid_o && n < 20);
      chk("latency", 80'(cyc - hs_cyc), 80'(3));
    end
    drain();
    // Backpressure during a 4-beat read.
    for (int k = 0; k < 4; k++) begin
      wd.push_back(64'h1111_1111_1111_1111 * 64'(k + 1));
      ws.push_back(8'hFF);
    end
    do_write(4'd1, 48'h100, 8'd3);
    drain();
    got_q.delete();
    do_read(4'd2, 48'h100, 8'd3);
    begin
      int n = 0;
      while (got_q.size() < 1 && n < 50) begin
        @(negedge clk_i);
        n++;
      end
    end
    rmode = 2;
    repeat (5) @(posedge clk_i);
    rmode = 0;
    drain();
    chk("bp_count", 80'(got_q.size()), 80'(4));
    for (int k = 0; k < 4; k++) chk("bp_data", 80'(got_q[k].d), 80'(64'h1111_1111_1111_1111 * 64'(k + 1)));
    // Window edge: last in-window word then first out-of-window word.
    got_q.delete();
    do_read(4'd4, SPAN - 48'(NB), 8'd1);
    drain();
    chk("oow_rd0_resp", 80'(got_q[0].r), 80'(2'b00));
    chk("oow_rd1", 80'(got_q[1]), 80'({1'b1, 4'd4, 64'h0, 2'b10, 1'b1}));
    wd.push_back(64'h1234);
    ws.push_back(8'hFF);
    wd.push_back(64'h5678);
    ws.push_back(8'hFF);
    got_q.delete();
    do_write(4'd4, SPAN - 48'(NB), 8'd1);
    drain();
    chk("oow_b", 80'(got_q[0]), 80'({1'b0, 4'd4, 64'h0, 2'b10, 1'b1}));
    // Address wrap at the top of the address space back into the window.
    do_read(4'd6, 48'hFFFF_FFFF_FFF8, 8'd1);
    drain();
    // Partial strobe overwrite.
    wd.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    ws.push_back(8'hFF);
    do_write(4'd8, 48'h40, 8'd0);
    wd.push_back(64'h11);
    ws.push_back(8'h01);
    do_write(4'd8, 48'h40, 8'd0);
    got_q.delete();
    do_read(4'd8, 48'h40, 8'd0);
    drain();
    chk("strb", 80'(got_q[got_q.size() - 1].d), 80'(64'hFFFF_FFFF_FFFF_FF11));
    // Early last flag.
    wd.push_back(64'h1);
    ws.push_back(8'hFF);
    wd.push_back(64'h2);
    ws.push_back(8'hFF);
    got_q.delete();
    do_write(4'd9, 48'h80, 8'd3);
    drain();
    chk("len_mismatch", 80'(got_q[0].r), 80'(2'b10));
    // Reset in the middle of a read burst.
    got_q.delete();
    do_read(4'd10, 48'h0, 8'd7);
    begin
      int n = 0;
      logic seen;
      while (got_q.size() < 2 && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      exp_q.delete();
      req_type_i = 2'd2;
      @(negedge clk_i);
      chk("rst_mid_ready", 80'(req_ready_o), 80'(0));
      chk("rst_mid_valid", 80'(rsp_valid_o), 80'(0));
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk_i);
        seen |= rsp_valid_o;
      end
      chk("rst_no_rsp", 80'(seen), 80'(0));
      @(posedge clk_i);
      #1;
    end
    do_read(4'd11, 48'h10, 8'd1);
    drain();
    // Randomized traffic with random response backpressure.
    rmode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [47:0] a;
      logic [7:0] len;
      logic [3:0] id;
      int n;
      a = 48'($urandom_range(0, 2200));
      if ($urandom_range(0, 9) == 0) a = 48'hFFFF_FFFF_FF00 + 48'($urandom_range(0, 255));
      len = 8'($urandom_range(0, 7));
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(id, a, len);
      else begin
        n = int'(len) + 1;
        if ($urandom_range(0, 7) == 0) n = $urandom_range(1, 9);
        for (int k = 0; k < n; k++) begin
          wd.push_back({$urandom, $urandom});
          ws.push_back(8'($urandom));
        end
        do_write(id, a, len);
      end
    end
    drain();
    rmode = 0;
    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
